// File: rtl/rv_decode_stage_pkg.sv
// Shared decode constants and types for the RV32I-subset decode stage.
package rv_decode_stage_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [1:0] {IMM_I, IMM_S, IMM_B} imm_type_e;

  // Control bundle carried into Execute.
  typedef struct packed {
    logic       reg_write;
    logic       alu_src;
    logic       mem_write;
    logic       mem_read;
    logic       result_src;
    logic       branch;
    logic [2:0] alu_control;
  } ctrl_t;

  // ALU operation from opcode/funct3/funct7[5]; funct7[5] only selects sub for R-type.
  function automatic logic [2:0] alu_decode(logic [6:0] opcode, logic [2:0] funct3,
                                            logic funct7b5);
    logic [2:0] op;
    op = ALU_ADD;
    unique case (opcode)
      OP_BRANCH: op = ALU_SUB;
      OP_RTYPE, OP_IALU: begin
        case (funct3)
          3'b000:  op = (opcode == OP_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b111:  op = ALU_AND;
          3'b110:  op = ALU_OR;
          3'b010:  op = ALU_SLT;
          default: op = ALU_ADD;
        endcase
      end
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv_decode_stage_regfile.sv
// 2-read/1-write register file, x0 hardwired to zero, synchronous clear.
// Optional same-edge write-to-read forwarding under `REGFILE_BYPASS_EN.
module rv_regfile #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [4:0]      raddr1_i,
  input  logic [4:0]      raddr2_i,
  output logic [XLEN-1:0] rdata1_o,
  output logic [XLEN-1:0] rdata2_o,
  input  logic            we_i,
  input  logic [4:0]      waddr_i,
  input  logic [XLEN-1:0] wdata_i
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  // Next-state: single write port, writes to x0 dropped.
  always_comb begin
    regs_d = regs_q;
    if (we_i && (waddr_i != 5'd0)) begin
      regs_d[waddr_i] = wdata_i;
    end
  end

  // Storage update with synchronous clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read ports; x0 forced to zero regardless of storage.
  always_comb begin
    rdata1_o = (raddr1_i == 5'd0) ? '0 : regs_q[raddr1_i];
    rdata2_o = (raddr2_i == 5'd0) ? '0 : regs_q[raddr2_i];
`ifdef REGFILE_BYPASS_EN
    if (we_i && (waddr_i != 5'd0) && (waddr_i == raddr1_i)) rdata1_o = wdata_i;
    if (we_i && (waddr_i != 5'd0) && (waddr_i == raddr2_i)) rdata2_o = wdata_i;
`endif
  end

endmodule

// File: rtl/rv_decode_stage.sv
// RV32I-subset decode stage: control decode, immediate extension, register file
// and the ID/EX pipeline register. Define REGFILE_BYPASS_EN to forward a
// same-cycle writeback into the read ports.
module rv_decode_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            Flush,
  input  logic [31:0]     InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            RegWriteW,
  input  logic [4:0]      RDW,
  input  logic [XLEN-1:0] ResultW,
  output logic            RegWriteE,
  output logic            ALUSrcE,
  output logic            MemWriteE,
  output logic            MemReadE,
  output logic            ResultSrcE,
  output logic            BranchE,
  output logic [2:0]      ALUControlE,
  output logic [XLEN-1:0] RD1_E,
  output logic [XLEN-1:0] RD2_E,
  output logic [XLEN-1:0] Imm_Ext_E,
  output logic [4:0]      RD_E,
  output logic [4:0]      RS1_E,
  output logic [4:0]      RS2_E,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E
);

  import rv_decode_stage_pkg::*;

  logic [6:0]      opcode;
  logic            sign;
  ctrl_t           dec_ctrl;
  logic            imm_en;
  imm_type_e       imm_type;
  logic [XLEN-1:0] imm_ext;
  logic [XLEN-1:0] rd1, rd2;

  assign opcode = InstrD[6:0];
  assign sign   = InstrD[31];

  rv_regfile #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_regfile (
    .clk_i    (clk),
    .rst_i    (rst),
    .raddr1_i (InstrD[19:15]),
    .raddr2_i (InstrD[24:20]),
    .rdata1_o (rd1),
    .rdata2_o (rd2),
    .we_i     (RegWriteW),
    .waddr_i  (RDW),
    .wdata_i  (ResultW)
  );

  // Main decoder: control flags and immediate format per opcode.
  always_comb begin
    dec_ctrl = '0;
    imm_en   = 1'b0;
    imm_type = IMM_I;
    unique case (opcode)
      OP_RTYPE: begin
        dec_ctrl.reg_write = 1'b1;
      end
      OP_IALU: begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
        imm_en             = 1'b1;
      end
      OP_LOAD: begin
        dec_ctrl.reg_write  = 1'b1;
        dec_ctrl.alu_src    = 1'b1;
        dec_ctrl.mem_read   = 1'b1;
        dec_ctrl.result_src = 1'b1;
        imm_en              = 1'b1;
      end
      OP_STORE: begin
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.mem_write = 1'b1;
        imm_en             = 1'b1;
        imm_type           = IMM_S;
      end
      OP_BRANCH: begin
        dec_ctrl.branch = 1'b1;
        imm_en          = 1'b1;
        imm_type        = IMM_B;
      end
      default: ;
    endcase
    // Unknown opcodes fall through to ALU_ADD (all-zero) in alu_decode.
    dec_ctrl.alu_control = alu_decode(opcode, InstrD[14:12], InstrD[30]);
  end

  // Sign-extended immediate; zero for formats without one.
  always_comb begin
    imm_ext = '0;
    if (imm_en) begin
      unique case (imm_type)
        IMM_I:   imm_ext = {{(XLEN-12){sign}}, InstrD[31:20]};
        IMM_S:   imm_ext = {{(XLEN-12){sign}}, InstrD[31:25], InstrD[11:7]};
        IMM_B:   imm_ext = {{(XLEN-12){sign}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
        default: imm_ext = '0;
      endcase
    end
  end

  ctrl_t           ctrl_q, ctrl_d;
  logic [XLEN-1:0] rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
  logic [4:0]      rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [XLEN-1:0] pc_q, pc_d, pc_plus4_q, pc_plus4_d;

  // ID/EX next state: a flush loads an all-zero bubble.
  always_comb begin
    ctrl_d     = dec_ctrl;
    rd1_d      = rd1;
    rd2_d      = rd2;
    imm_d      = imm_ext;
    rd_d       = InstrD[11:7];
    rs1_d      = InstrD[19:15];
    rs2_d      = InstrD[24:20];
    pc_d       = PCD;
    pc_plus4_d = PCPlus4D;
    if (Flush) begin
      ctrl_d     = '0;
      rd1_d      = '0;
      rd2_d      = '0;
      imm_d      = '0;
      rd_d       = '0;
      rs1_d      = '0;
      rs2_d      = '0;
      pc_d       = '0;
      pc_plus4_d = '0;
    end
  end

  // ID/EX register; reset outranks flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q     <= '0;
      rd1_q      <= '0;
      rd2_q      <= '0;
      imm_q      <= '0;
      rd_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      pc_q       <= '0;
      pc_plus4_q <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      rd1_q      <= rd1_d;
      rd2_q      <= rd2_d;
      imm_q      <= imm_d;
      rd_q       <= rd_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
    end
  end

  assign RegWriteE   = ctrl_q.reg_write;
  assign ALUSrcE     = ctrl_q.alu_src;
  assign MemWriteE   = ctrl_q.mem_write;
  assign MemReadE    = ctrl_q.mem_read;
  assign ResultSrcE  = ctrl_q.result_src;
  assign BranchE     = ctrl_q.branch;
  assign ALUControlE = ctrl_q.alu_control;
  assign RD1_E       = rd1_q;
  assign RD2_E       = rd2_q;
  assign Imm_Ext_E   = imm_q;
  assign RD_E        = rd_q;
  assign RS1_E       = rs1_q;
  assign RS2_E       = rs2_q;
  assign PCE         = pc_q;
  assign PCPlus4E    = pc_plus4_q;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Bench for rv_decode_stage: directed vector table, hand sequences for
// writeback/flush interaction, then random instructions against a reference model.
module tb_rv_decode_stage;

  typedef struct packed {
    logic        rw, as, mw, mr, rs, br;
    logic [2:0]  alu;
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] pc, pc4;
  } out_t;

  typedef struct {
    logic        rst, flush;
    logic [31:0] instr, pc, pc4;
    logic        we;
    logic [4:0]  rdw;
    logic [31:0] res;
    logic        chk_imm;
    out_t        exp;
  } vec_t;

`ifdef REGFILE_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, Flush, RegWriteW;
  logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
  logic [4:0]  RDW;
  logic        RegWriteE, ALUSrcE, MemWriteE, MemReadE, ResultSrcE, BranchE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
  logic [4:0]  RD_E, RS1_E, RS2_E;

  int checks = 0;
  int errors = 0;
  logic [31:0] mrf [32];

  rv_decode_stage dut (
    .clk         (clk),
    .rst         (rst),
    .Flush       (Flush),
    .InstrD      (InstrD),
    .PCD         (PCD),
    .PCPlus4D    (PCPlus4D),
    .RegWriteW   (RegWriteW),
    .RDW         (RDW),
    .ResultW     (ResultW),
    .RegWriteE   (RegWriteE),
    .ALUSrcE     (ALUSrcE),
    .MemWriteE   (MemWriteE),
    .MemReadE    (MemReadE),
    .ResultSrcE  (ResultSrcE),
    .BranchE     (BranchE),
    .ALUControlE (ALUControlE),
    .RD1_E       (RD1_E),
    .RD2_E       (RD2_E),
    .Imm_Ext_E   (Imm_Ext_E),
    .RD_E        (RD_E),
    .RS1_E       (RS1_E),
    .RS2_E       (RS2_E),
    .PCE         (PCE),
    .PCPlus4E    (PCPlus4E)
  );

  always #5 clk = ~clk;

  function automatic out_t sample();
    sample = '{RegWriteE, ALUSrcE, MemWriteE, MemReadE, ResultSrcE, BranchE, ALUControlE,
               RD1_E, RD2_E, Imm_Ext_E, RD_E, RS1_E, RS2_E, PCE, PCPlus4E};
  endfunction

  function automatic out_t mk_out(bit rw, bit as, bit mw, bit mr, bit rs, bit br,
                                  logic [2:0] alu, logic [31:0] rd1, logic [31:0] rd2,
                                  logic [31:0] imm, logic [4:0] rd, logic [4:0] rs1,
                                  logic [4:0] rs2, logic [31:0] pc, logic [31:0] pc4);
    mk_out = '{rw, as, mw, mr, rs, br, alu, rd1, rd2, imm, rd, rs1, rs2, pc, pc4};
  endfunction

  function automatic vec_t mk(bit r, bit f, logic [31:0] ins, logic [31:0] pc,
                              logic [31:0] pc4, bit we, logic [4:0] rdw, logic [31:0] res,
                              bit ci, out_t e);
    vec_t v;
    v.rst = r; v.flush = f; v.instr = ins; v.pc = pc; v.pc4 = pc4;
    v.we = we; v.rdw = rdw; v.res = res; v.chk_imm = ci; v.exp = e;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic cmp_out(string tag, out_t g, out_t e, bit chk_imm);
    chk({tag, ".RegWriteE"},   32'(g.rw),  32'(e.rw));
    chk({tag, ".ALUSrcE"},     32'(g.as),  32'(e.as));
    chk({tag, ".MemWriteE"},   32'(g.mw),  32'(e.mw));
    chk({tag, ".MemReadE"},    32'(g.mr),  32'(e.mr));
    chk({tag, ".ResultSrcE"},  32'(g.rs),  32'(e.rs));
    chk({tag, ".BranchE"},     32'(g.br),  32'(e.br));
    chk({tag, ".ALUControlE"}, 32'(g.alu), 32'(e.alu));
    chk({tag, ".RD1_E"},       g.rd1,      e.rd1);
    chk({tag, ".RD2_E"},       g.rd2,      e.rd2);
    if (chk_imm) chk({tag, ".Imm_Ext_E"}, g.imm, e.imm);
    chk({tag, ".RD_E"},        32'(g.rd),  32'(e.rd));
    chk({tag, ".RS1_E"},       32'(g.rs1), 32'(e.rs1));
    chk({tag, ".RS2_E"},       32'(g.rs2), 32'(e.rs2));
    chk({tag, ".PCE"},         g.pc,       e.pc);
    chk({tag, ".PCPlus4E"},    g.pc4,      e.pc4);
  endtask

  // Reference register read: x0 is zero; with forwarding a same-cycle write wins.
  function automatic logic [31:0] m_read(logic [4:0] idx, bit we, logic [4:0] rdw,
                                         logic [31:0] res);
    if (idx == 5'd0) return 32'd0;
    if (Bypass && we && rdw == idx) return res;
    return mrf[idx];
  endfunction

  function automatic logic [2:0] m_alu(int f3, bit sub_ok);
    if (f3 == 7) return 3'b010;
    if (f3 == 6) return 3'b011;
    if (f3 == 2) return 3'b101;
    if (f3 == 0 && sub_ok) return 3'b001;
    return 3'b000;
  endfunction

  // Reference decode using integer arithmetic on the instruction word.
  function automatic out_t m_decode(logic [31:0] ins, logic [31:0] pc, logic [31:0] pc4,
                                    bit we, logic [4:0] rdw, logic [31:0] res);
    out_t o = '0;
    int   sx = $signed(ins);
    int   f3 = int'(ins[14:12]);
    o.rd  = ins[11:7];
    o.rs1 = ins[19:15];
    o.rs2 = ins[24:20];
    o.rd1 = m_read(ins[19:15], we, rdw, res);
    o.rd2 = m_read(ins[24:20], we, rdw, res);
    o.pc  = pc;
    o.pc4 = pc4;
    case (int'(ins[6:0]))
      'h33: begin o.rw = 1; o.alu = m_alu(f3, ins[30]); end
      'h13: begin o.rw = 1; o.as = 1; o.alu = m_alu(f3, 1'b0); o.imm = 32'(sx >>> 20); end
      'h03: begin o.rw = 1; o.as = 1; o.mr = 1; o.rs = 1; o.imm = 32'(sx >>> 20); end
      'h23: begin
        o.as = 1; o.mw = 1;
        o.imm = 32'((sx >>> 25) * 32 + int'(ins[11:7]));
      end
      'h63: begin
        o.br = 1; o.alu = 3'b001;
        o.imm = 32'((ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
                    + int'(ins[11:8]) * 2);
      end
      default: ;
    endcase
    return o;
  endfunction

  // Apply one cycle of inputs, track the model register file, sample #1 after the edge.
  task automatic drive(input bit r, input bit f, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] pc4, input bit we, input logic [4:0] rdw,
                       input logic [31:0] res, output out_t mexp);
    rst = r; Flush = f; InstrD = ins; PCD = pc; PCPlus4D = pc4;
    RegWriteW = we; RDW = rdw; ResultW = res;
    mexp = (r || f) ? out_t'(0) : m_decode(ins, pc, pc4, we, rdw, res);
    @(posedge clk);
    if (r) begin
      for (int k = 0; k < 32; k++) mrf[k] = 32'd0;
    end else if (we && rdw != 5'd0) begin
      mrf[rdw] = res;
    end
    #1;
  endtask

  initial begin
    vec_t        vecs [13];
    out_t        mexp, g;
    logic [6:0]  ops [5];
    logic [31:0] ins, res;
    logic [4:0]  rdw;
    bit          r, f, we;
    int          k;

    for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
    rst = 1'b1; Flush = 1'b0; InstrD = '0; PCD = '0; PCPlus4D = '0;
    RegWriteW = 1'b0; RDW = '0; ResultW = '0;

    vecs[0]  = mk(1, 0, 32'h00A00093, 0, 4, 0, 0, 0, 1, '0);
    vecs[1]  = mk(0, 0, 32'h00A00093, 0, 4, 0, 0, 0, 1,
                  mk_out(1, 1, 0, 0, 0, 0, 3'b000, 0, 0, 10, 1, 0, 10, 0, 4));
    vecs[2]  = mk(0, 0, 32'h40118233, 'h0C, 'h10, 0, 0, 0, 0,
                  mk_out(1, 0, 0, 0, 0, 0, 3'b001, 0, 0, 0, 4, 3, 1, 'h0C, 'h10));
    vecs[3]  = mk(0, 0, 32'h00402023, 'h10, 'h14, 0, 0, 0, 1,
                  mk_out(0, 1, 1, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 4, 'h10, 'h14));
    vecs[4]  = mk(0, 0, 32'h00002103, 'h14, 'h18, 0, 0, 0, 1,
                  mk_out(1, 1, 0, 1, 1, 0, 3'b000, 0, 0, 0, 2, 0, 0, 'h14, 'h18));
    vecs[5]  = mk(0, 1, 32'h001101B3, 'h18, 'h1C, 0, 0, 0, 1, '0);
    vecs[6]  = mk(0, 0, 32'h001101B3, 'h18, 'h1C, 0, 0, 0, 0,
                  mk_out(1, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 3, 2, 1, 'h18, 'h1C));
    vecs[7]  = mk(0, 0, 32'h00000000, 'h1C, 'h20, 1, 1, 10, 1,
                  mk_out(0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 'h1C, 'h20));
    vecs[8]  = mk(0, 0, 32'h002081B3, 'h20, 'h24, 1, 0, 32'hFFFFFFFF, 0,
                  mk_out(1, 0, 0, 0, 0, 0, 3'b000, 10, 0, 0, 3, 1, 2, 'h20, 'h24));
    vecs[9]  = mk(0, 0, 32'hFFF00093, 'h24, 'h28, 0, 0, 0, 1,
                  mk_out(1, 1, 0, 0, 0, 0, 3'b000, 0, 0, 32'hFFFFFFFF, 1, 0, 31, 'h24, 'h28));
    vecs[10] = mk(0, 0, 32'hFE000EE3, 'h28, 'h2C, 0, 0, 0, 1,
                  mk_out(0, 0, 0, 0, 0, 1, 3'b001, 0, 0, 32'hFFFFFFFC, 29, 0, 0, 'h28, 'h2C));
    vecs[11] = mk(1, 0, 32'h002081B3, 'h2C, 'h30, 1, 2, 5, 1, '0);
    vecs[12] = mk(0, 0, 32'h002081B3, 'h30, 'h34, 0, 0, 0, 0,
                  mk_out(1, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 3, 1, 2, 'h30, 'h34));

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].rst, vecs[i].flush, vecs[i].instr, vecs[i].pc, vecs[i].pc4,
            vecs[i].we, vecs[i].rdw, vecs[i].res, mexp);
      cmp_out($sformatf("vec%0d", i), sample(), vecs[i].exp, vecs[i].chk_imm);
    end

    // add x7,x5,x6 decoded in the same cycle x5 is written back.
    ins = {7'd0, 5'd6, 5'd5, 3'b000, 5'd7, 7'h33};
    drive(0, 0, ins, 'h40, 'h44, 1, 5, 32'h1234, mexp);
    chk("same_cycle_wb.RD1_E", RD1_E, Bypass ? 32'h1234 : 32'h0);
    // Flushed cycle still commits the x6 writeback.
    drive(0, 1, ins, 'h44, 'h48, 1, 6, 32'd77, mexp);
    chk("flush_wb.RD1_E", RD1_E, 32'h0);
    chk("flush_wb.RD_E", 32'(RD_E), 32'h0);
    drive(0, 0, ins, 'h48, 'h4C, 0, 0, 0, mexp);
    chk("after_wb.RD1_E", RD1_E, 32'h1234);
    chk("after_wb.RD2_E", RD2_E, 32'd77);

    ops[0] = 7'h33; ops[1] = 7'h13; ops[2] = 7'h03; ops[3] = 7'h23; ops[4] = 7'h63;
    for (int n = 0; n < 400; n++) begin
      ins = $urandom();
      k = $urandom_range(0, 5);
      if (k < 5) ins[6:0] = ops[k];
      r   = ($urandom_range(0, 49) == 0);
      f   = ($urandom_range(0, 9) == 0);
      we  = ($urandom_range(0, 2) == 0);
      rdw = 5'($urandom_range(0, 31));
      res = $urandom();
      drive(r, f, ins, $urandom(), $urandom(), we, rdw, res, mexp);
      g = sample();
      cmp_out($sformatf("rand%0d", n), g, mexp, r || f || (ins[6:0] != 7'h33));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv_decode_stage.md
Name: rv_decode_stage

Overview:
- RV32I-subset instruction decode stage of a 5-stage in-order pipeline.
- Contains the 32x32 register file, the main/ALU control decoder and the immediate extender.
- Ends in the ID/EX pipeline register, which latches control, operands, immediate, register indices and PC values for the Execute stage.
- A separate hazard-detection unit drives Flush to insert a bubble on load-use hazards.

Parameters:
- XLEN, 32, datapath/register width
- NREGS, 32, number of architectural registers (index width 5)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- Flush  in  1  clear ID/EX register this edge (bubble)
- InstrD  in  32  instruction in Decode
- PCD  in  32  PC of InstrD
- PCPlus4D  in  32  PC+4 of InstrD
- RegWriteW  in  1  writeback enable
- RDW  in  5  writeback destination
- ResultW  in  32  writeback data
- RegWriteE, ALUSrcE, MemWriteE, MemReadE, ResultSrcE, BranchE  out  1 each  registered control
- ALUControlE  out  3  registered ALU op
- RD1_E, RD2_E  out  32  registered rs1/rs2 values
- Imm_Ext_E  out  32  registered sign-extended immediate
- RD_E, RS1_E, RS2_E  out  5  registered rd/rs1/rs2 (InstrD[11:7], [19:15], [24:20])
- PCE, PCPlus4E  out  32  registered PCD/PCPlus4D

Behaviour:
- All outputs registered; latency 1 cycle from InstrD/PCD to *_E.
- Priority at each rising edge: rst > Flush > normal load.
- rst=1: every ID/EX output becomes 0; all register-file entries become 0.
- Flush=1 (rst=0): every ID/EX output becomes 0, i.e. a NOP bubble. The register-file write still occurs.
- Decode by opcode InstrD[6:0], giving RegWrite, ALUSrc, MemWrite, MemRead, ResultSrc, Branch, ImmType:
  - 0110011 R: 1,0,0,0,0,0,–
  - 0010011 I-ALU: 1,1,0,0,0,0,I
  - 0000011 lw: 1,1,0,1,1,0,I
  - 0100011 sw: 0,1,1,0,0,0,S
  - 1100011 beq: 0,0,0,0,0,1,B
  - Any other opcode: all controls 0, Imm=0.
- ALUControl (funct3=InstrD[14:12], funct7b5=InstrD[30]): 000 add, 001 sub, 010 and, 011 or, 101 slt.
  - lw/sw → add; beq → sub.
  - R-type: f3=000 is sub if funct7b5=1, else add; 111 → and; 110 → or; 010 → slt.
  - I-ALU: f3=000 → add (funct7b5 ignored); 111 → and; 110 → or; 010 → slt.
  - Unlisted funct3 → add.
- Immediates (sign bit InstrD[31]):
  - I = {20{i31}, i[31:20]}
  - S = {20{i31}, i[31:25], i[11:7]}
  - B = {19{i31}, i31, i7, i[30:25], i[11:8], 0}
- Register file:
  - Two combinational read ports on InstrD[19:15] and InstrD[24:20].
  - One synchronous write on the rising edge when RegWriteW=1 and RDW≠0.
  - x0 always reads 0; writes to x0 are ignored.
- Same-edge write and read of the same register is handled by the bypass (see Optional Feature).
- RD_E, RS1_E and RS2_E are latched for every opcode, regardless of format.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: if RegWriteW=1, RDW≠0 and RDW equals a read index, that read port returns ResultW. The value latched into RD1_E/RD2_E is therefore the new value in the same cycle.
- Undefined: reads return the stored value, and the new value is visible from the next cycle. The bench then requires a gap of one cycle between write and dependent decode.

Decomposition:
- Shared package holds:
  - Opcode constants OP_RTYPE, OP_IALU, OP_LOAD, OP_STORE, OP_BRANCH.
  - ALU op constants ALU_ADD=000, ALU_SUB=001, ALU_AND=010, ALU_OR=011, ALU_SLT=101.
  - Immediate-type enum {IMM_I, IMM_S, IMM_B}.
- One natural sub-module: rv_regfile (32x32, 2R1W, x0 hardwired, optional bypass).
- Control decode and immediate extension are combinational logic inside the top-level module.
- The hazard unit is external.

Test Plan:
- rst=1 one edge, then rst=0 with InstrD=0x00A00093 (addi x1,x0,10): after reset, all outputs 0; next edge RegWriteE=1, ALUSrcE=1, ALUControlE=000, Imm_Ext_E=10, RD_E=1, RS1_E=0, PCPlus4E=0x04.
- InstrD=0x40118233 (sub x4,x3,x1), PCD=0x0C: ALUControlE=001, RegWriteE=1, ALUSrcE=0, RD_E=4, RS1_E=3, RS2_E=1, PCE=0x0C.
- InstrD=0x00402023 (sw x4,0(x0)) → MemWriteE=1, RegWriteE=0, Imm_Ext_E=0, RS2_E=4. Then InstrD=0x00002103 (lw x2) → MemReadE=1, ResultSrcE=1, RD_E=2.
- Load-use: with lw x2 in E, InstrD=0x001101B3 and Flush=1 → next edge all E outputs 0. With Flush=0 → RD_E=3, RS1_E=2.
- Writeback: RegWriteW=1, RDW=1, ResultW=10, then InstrD=0x002081B3 → RD1_E=10. Write RDW=0 with ResultW=0xFFFFFFFF → reads of x0 give 0.
- Negative immediate: InstrD=0xFFF00093 (addi x1,x0,-1) → Imm_Ext_E=0xFFFFFFFF. beq 0xFE000EE3 → BranchE=1, ALUControlE=001, Imm_Ext_E=0xFFFFFFFC.
